// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC sequencing, instruction-memory handshake, one-entry skid and redirect drain.
// Defining FETCH_ALIGN_CHK_EN enables the sticky misaligned-fetch trap on err.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] newPC,
    input  logic        redirect,
    input  logic        stall,
    input  logic        halt,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] incPC,
    output logic        instr_valid,
    output logic        err
);

    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] { FETCH, DRAIN, HOLD, HALTED } stateType;

    stateType    state;
    logic [15:0] pc;
    logic [15:0] pcPlus2;
    logic [15:0] skidData;
    logic [15:0] issueAddr;
    logic        accept;
    logic        consume;
    logic        issue;
    logic        holdReq;
    logic        badAlign;
    logic        rdNext;

    assign pcPlus2 = pc + 16'd2;
    assign accept  = imem_rd && imem_done;
    assign consume = instr_valid && !stall;

    // Decide whether a new read starts at the coming edge, and at which address.
    always_comb begin
        // NOTE: every output gets a default first, so no latch is inferred.
        issue     = 1'b0;
        issueAddr = pc;
        if (state != HALTED) begin
            if (redirect) begin
                issue     = !(imem_rd && !imem_done);
                issueAddr = newPC;
            end else if (!halt) begin
                case (state)
                    FETCH: begin
                        if (accept) begin
                            issue     = !stall;
                            issueAddr = pcPlus2;
                        end else if (!imem_rd) begin
                            issue = !(instr_valid && stall);
                        end
                    end
                    HOLD:    issue = !stall;
                    DRAIN:   issue = imem_done;
                    default: issue = 1'b0;
                endcase
            end
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    logic errQ;

    assign badAlign = issue && issueAddr[0];
    assign err      = errQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            errQ <= 1'b0;
        else if (badAlign)
            errQ <= 1'b1;
    end
`else
    assign badAlign = 1'b0;
    assign err      = 1'b0;
`endif

    // An issued read keeps imem_rd high and its address frozen until done, even through a redirect.
    assign holdReq = imem_rd && !imem_done && (redirect || !halt);
    assign rdNext  = (issue && !badAlign) || holdReq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= 16'h0000;
            instr       <= NOP;
            incPC       <= 16'h0002;
            instr_valid <= 1'b0;
            imem_rd     <= 1'b0;
            imem_addr   <= 16'h0000;
            skidData    <= 16'h0000;
        end else begin
            imem_rd <= rdNext;
            if (issue && !badAlign)
                imem_addr <= issueAddr;

            if (state != HALTED) begin
                if (redirect) begin
                    pc          <= newPC;
                    instr_valid <= 1'b0;
                    state       <= (imem_rd && !imem_done) ? DRAIN : FETCH;
                end else if (halt) begin
                    instr_valid <= 1'b0;
                    state       <= HALTED;
                end else begin
                    case (state)
                        FETCH: begin
                            if (accept && instr_valid && stall) begin
                                skidData <= imem_data;
                                pc       <= pcPlus2;
                                state    <= HOLD;
                            end else if (accept) begin
                                instr       <= imem_data;
                                incPC       <= pcPlus2;
                                instr_valid <= 1'b1;
                                pc          <= pcPlus2;
                            end else if (consume) begin
                                instr_valid <= 1'b0;
                            end
                        end
                        HOLD: begin
                            // pc already points past the skid entry, so it is the entry's incPC.
                            if (!stall) begin
                                instr       <= skidData;
                                incPC       <= pc;
                                instr_valid <= 1'b1;
                                state       <= FETCH;
                            end
                        end
                        DRAIN: begin
                            if (imem_done)
                                state <= FETCH;
                        end
                        default: ;
                    endcase
                end

                // NOTE: a later non-blocking assignment in the same block overrides earlier ones.
                if (badAlign) begin
                    instr_valid <= 1'b0;
                    state       <= HALTED;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed handshake scenarios, then random traffic
// checked against an in-order instruction-stream model with a random-latency memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] newPC;
    logic        redirect;
    logic        stall;
    logic        halt;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_done;
    logic [15:0] instr;
    logic [15:0] incPC;
    logic        instr_valid;
    logic        err;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [15:0] expPC;
    logic [15:0] reqAddr;
    bit          reqActive;
    int          waitCnt;
    int          lat;
    int          idle;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .newPC       (newPC),
        .redirect    (redirect),
        .stall       (stall),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .imem_done   (imem_done),
        .instr       (instr),
        .incPC       (incPC),
        .instr_valid (instr_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memFn(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        check(tag, 16'(obs), 16'(exp));
    endtask

    task automatic drive(input logic rdir, input logic [15:0] np, input logic st,
                         input logic hl, input logic dn, input logic [15:0] dat);
        redirect  = rdir;
        newPC     = np;
        stall     = st;
        halt      = hl;
        imem_done = dn;
        imem_data = dat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkBit({tag, " rd"}, imem_rd, 1'b0);
        check({tag, " instr"}, instr, 16'h0800);
        check({tag, " incPC"}, incPC, 16'h0002);
        checkBit({tag, " valid"}, instr_valid, 1'b0);
        checkBit({tag, " err"}, err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        #12;
        checkReset("reset");
        check("reset addr", imem_addr, 16'h0000);
        rst_n = 1'b1;

        // Back-to-back reads with done in the request cycle.
        step();
        checkBit("first rd", imem_rd, 1'b1);
        check("first addr", imem_addr, 16'h0000);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1111);
        step();
        check("seq instr0", instr, 16'h1111);
        check("seq incPC0", incPC, 16'h0002);
        checkBit("seq valid0", instr_valid, 1'b1);
        check("seq addr1", imem_addr, 16'h0002);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h2222);
        step();
        check("seq instr1", instr, 16'h2222);
        check("seq incPC1", incPC, 16'h0004);
        checkBit("seq valid1", instr_valid, 1'b1);

        // Slow memory: done three cycles late at 0x0004.
        for (int i = 0; i < 3; i++) begin
            checkBit("slow rd", imem_rd, 1'b1);
            check("slow addr", imem_addr, 16'h0004);
            if (i > 0) checkBit("slow valid", instr_valid, 1'b0);
            drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
            step();
        end
        checkBit("slow rd last", imem_rd, 1'b1);
        check("slow addr last", imem_addr, 16'h0004);
        checkBit("slow valid last", instr_valid, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h3333);
        step();
        check("slow instr", instr, 16'h3333);
        check("slow incPC", incPC, 16'h0006);
        checkBit("slow rd next", imem_rd, 1'b1);
        check("slow addr next", imem_addr, 16'h0006);

        // Stall rises while the read at 0x0006 completes: data parks in the skid entry.
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h4444);
        step();
        check("skid instr held", instr, 16'h3333);
        checkBit("skid valid held", instr_valid, 1'b1);
        checkBit("skid no req", imem_rd, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        check("skid instr held2", instr, 16'h3333);
        checkBit("skid no req2", imem_rd, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        check("skid instr out", instr, 16'h4444);
        check("skid incPC out", incPC, 16'h0008);
        checkBit("skid valid out", instr_valid, 1'b1);
        checkBit("skid resume rd", imem_rd, 1'b1);
        check("skid resume addr", imem_addr, 16'h0008);

        // Redirect to 0x0010, then redirect to 0x0040 while that read is pending.
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h5555);
        step();
        checkBit("rdir valid", instr_valid, 1'b0);
        check("rdir addr", imem_addr, 16'h0010);
        drive(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        checkBit("drain rd", imem_rd, 1'b1);
        check("drain addr", imem_addr, 16'h0010);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        check("drain addr2", imem_addr, 16'h0010);
        checkBit("drain valid", instr_valid, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        step();
        checkBit("drain discard", instr_valid, 1'b0);
        check("drain new addr", imem_addr, 16'h0040);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h6666);
        step();
        check("drain instr", instr, 16'h6666);
        check("drain incPC", incPC, 16'h0042);

        // Redirect and halt together: redirect wins.
        drive(1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, 16'h1234);
        step();
        checkBit("rh rd", imem_rd, 1'b1);
        check("rh addr", imem_addr, 16'h0100);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7777);
        step();
        check("rh instr", instr, 16'h7777);
        check("rh incPC", incPC, 16'h0102);

        // Halt alone freezes fetch; later redirects are ignored.
        drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
        step();
        checkBit("halt rd", imem_rd, 1'b0);
        checkBit("halt valid", instr_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 16'h0);
            step();
            checkBit("halted rd", imem_rd, 1'b0);
            checkBit("halted valid", instr_valid, 1'b0);
        end

        // Reset exits HALTED; a second reset aborts a pending read.
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        #1;
        checkReset("rst2");
        rst_n = 1'b1;
        step();
        checkBit("rst2 rd", imem_rd, 1'b1);
        check("rst2 addr", imem_addr, 16'h0000);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("abort");
        rst_n = 1'b1;
        step();
        checkBit("abort reissue", imem_rd, 1'b1);
        check("abort addr", imem_addr, 16'h0000);

        // PC wraps from 0xFFFE to 0x0000.
        drive(1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 16'h9999);
        step();
        check("wrap addr", imem_addr, 16'hFFFE);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hBBBB);
        step();
        check("wrap instr", instr, 16'hBBBB);
        check("wrap incPC", incPC, 16'h0000);
        check("wrap next addr", imem_addr, 16'h0000);

        // Odd redirect target.
        drive(1'b1, 16'h0013, 1'b0, 1'b0, 1'b1, 16'hCCCC);
        step();
`ifdef FETCH_ALIGN_CHK_EN
        checkBit("align err", err, 1'b1);
        checkBit("align no rd", imem_rd, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        checkBit("align err sticky", err, 1'b1);
        checkBit("align halted", imem_rd, 1'b0);
`else
        checkBit("odd err", err, 1'b0);
        checkBit("odd rd", imem_rd, 1'b1);
        check("odd addr", imem_addr, 16'h0013);
`endif

        // Random traffic against the in-order stream model.
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        rst_n     = 1'b1;
        expPC     = 16'h0000;
        reqActive = 1'b0;
        waitCnt   = 0;
        lat       = 0;
        idle      = 0;
        reqAddr   = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            logic        st;
            logic        rdir;
            logic        dn;
            logic [15:0] np;

            if (reqActive) begin
                checkBit("rnd rd held", imem_rd, 1'b1);
                check("rnd addr held", imem_addr, reqAddr);
            end

            st   = ($urandom % 4) == 0;
            rdir = ($urandom % 16) == 0;
            np   = (($urandom % 8) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);

            dn = 1'b0;
            if (imem_rd) begin
                if (!reqActive) begin
                    reqActive = 1'b1;
                    waitCnt   = 0;
                    lat       = int'($urandom % 4);
                    reqAddr   = imem_addr;
                end
                if (waitCnt == lat) begin
                    dn        = 1'b1;
                    reqActive = 1'b0;
                end else begin
                    waitCnt++;
                end
            end

            if (rdir) begin
                expPC = np;
            end else if (instr_valid && !st) begin
                check("rnd instr", instr, memFn(expPC));
                check("rnd incPC", incPC, expPC + 16'd2);
                expPC = expPC + 16'd2;
                idle  = 0;
            end

            drive(rdir, np, st, 1'b0, dn, memFn(imem_addr));
            step();
            idle++;
            if (idle > 60) begin
                check("rnd progress", 16'(idle), 16'd0);
                idle = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 newPC  in  16  redirect target from execute (branch/jump/JR/JAL result).
REQ-005 redirect  in  1  execute resolved a taken control transfer this cycle.
REQ-006 stall  in  1  decode cannot accept the instruction presented on instr.
REQ-007 halt  in  1  decode saw HALT; fetch freezes.
REQ-008 imem_addr  out  16  instruction memory word address (byte PC).
REQ-009 imem_rd  out  1  read request; held high with imem_addr stable until imem_done.
REQ-010 imem_data  in  16  read data; valid only when imem_done=1.
REQ-011 imem_done  in  1  read complete; may arrive in the request cycle or any later cycle.
REQ-012 instr  out  16  instruction presented to decode.
REQ-013 incPC  out  16  PC of instr plus 2.
REQ-014 instr_valid  out  1  instr/incPC valid; consumed in any cycle with instr_valid=1 and stall=0.
REQ-015 err  out  1  sticky misalignment flag (see Configuration).

Function
REQ-016 The block SHALL hold a 16-bit fetch PC and a state machine with states FETCH, DRAIN, HOLD, HALTED.
REQ-017 FETCH: imem_rd=1, imem_addr=PC, unless instr_valid=1 and stall=1 (then imem_rd=0, no new request).
REQ-018 FETCH, imem_done=1, output slot free or being consumed: next cycle instr<=imem_data, incPC<=PC+2, instr_valid<=1, PC<=PC+2 (1-cycle latency done->instr).
REQ-019 FETCH, imem_done=1, instr_valid=1 and stall=1 (stall rose mid-request): data SHALL go to a one-entry skid register, PC<=PC+2, state<=HOLD.
REQ-020 HOLD: imem_rd=0; instr/instr_valid held stable; on first cycle with stall=0 the skid entry SHALL move to instr next cycle, state<=FETCH.
REQ-021 No output slot consumed and no new data: instr, incPC, instr_valid SHALL hold.
REQ-022 redirect=1 in any non-HALTED state SHALL: PC<=newPC, instr_valid<=0, skid cleared; state<=DRAIN if a request is outstanding without imem_done this cycle, else FETCH.
REQ-023 DRAIN: imem_rd stays high with the old address until imem_done; returned data SHALL be discarded; then state<=FETCH issuing at newPC.
REQ-024 redirect during DRAIN SHALL overwrite PC with the newer newPC and remain in DRAIN.
REQ-025 redirect and halt in the same cycle: redirect SHALL win (halt belongs to a younger instruction).
REQ-026 halt=1 without redirect: state<=HALTED, instr_valid<=0, imem_rd<=0; any outstanding done is ignored; only reset exits HALTED.
REQ-027 PC arithmetic SHALL wrap modulo 2^16 (0xFFFE+2=0x0000) with no flag.

Reset
REQ-028 With rst_n=0: PC=0x0000, instr=0x0800 (NOP), incPC=0x0002, instr_valid=0, imem_rd=0, err=0, skid empty, state FETCH.
REQ-029 First request (imem_addr=0x0000) SHALL issue in the first cycle after rst_n deasserts; reset mid-request aborts it without waiting for imem_done.

Configuration
REQ-030 Macro FETCH_ALIGN_CHK_EN: when defined, a FETCH request with PC[0]=1 SHALL not issue; err<=1 (sticky), state<=HALTED.
REQ-031 Without FETCH_ALIGN_CHK_EN, err SHALL be tied 0 and PC[0] passed unchanged to imem_addr.

Verification
REQ-032 Reset release, imem_done=1 every cycle, data 0x1111,0x2222 -> instr 0x1111/incPC 0x0002 then 0x2222/0x0004, instr_valid continuous.
REQ-033 imem_done delayed 3 cycles at PC 0x0004 -> imem_rd/imem_addr stable 0x0004 for 4 cycles, instr_valid low until data.
REQ-034 stall high 2 cycles while next done arrives -> instr held, skid holds data, no request; stall low -> skid data on instr next cycle, no loss/duplicate.
REQ-035 redirect newPC=0x0040 during pending read at 0x0010, done 2 cycles later -> that data discarded, next imem_addr=0x0040.
REQ-036 redirect and halt same cycle, newPC=0x0100 -> fetch at 0x0100 continues; halt alone -> imem_rd=0 permanently until rst_n.
REQ-037 With FETCH_ALIGN_CHK_EN, redirect newPC=0x0013 -> err=1, no request, HALTED; without macro -> imem_addr=0x0013.
